data_sel_arb: RTL and testbench
===============================

// Module: data_sel_arb
// PURPOSE
//  Parametrised, registered N-channel data selector with a valid/ready handshake.
//  It selects one of N_CH input channels, either by a fixed index (sel) or by
//  round-robin arbitration. The chosen word goes into a single output register
//  stage, tagged with its source channel.
//  It sits between several producers and one consumer in the datapath.
//  It is the sequential, multi-bit successor of the team's 4:1 1-bit data selector.
// PARAMETERS
//  N_CH   4   number of input channels (>=2)
//  WIDTH  8   data width per channel
//  SEL_W  $clog2(N_CH)  localparam; width of sel and out_ch
// PORTS
//  clk        in   1            clock; all logic on rising edge
//  rst_n      in   1            asynchronous active-low reset
//  mode       in   1            0 = fixed select by sel, 1 = round-robin
//  sel        in   SEL_W        channel index used when mode=0
//  in_valid   in   N_CH         per-channel request/valid
//  in_data    in   N_CH*WIDTH   channel i at bits [i*WIDTH +: WIDTH]
//  in_ready   out  N_CH         per-channel accept (combinational)
//  out_valid  out  1            output register holds a word
//  out_data   out  WIDTH        registered selected word
//  out_ch     out  SEL_W        source channel of out_data
//  out_ready  in   1            consumer accepts out_data this cycle
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=N_CH-1.
//  - With rr_ptr=N_CH-1, the first RR grant goes to channel 0.
//  load_en = !out_valid | out_ready; output stage accepts a new word when load_en=1.
//  Grant (one-hot, combinational, depends only on current inputs and rr_ptr):
//  - mode=0: grant[sel] = in_valid[sel]. If sel >= N_CH, there is no grant.
//  - mode=1: first i with in_valid[i] set, searching cyclically from rr_ptr+1.
//  in_ready[i] = grant[i] & load_en. At most one in_ready bit is high per cycle.
//  A transfer on channel i happens when in_valid[i] & in_ready[i].
//  On a transfer, next edge: out_data <= channel i word, out_ch <= i, out_valid <= 1.
//  Latency is 1 cycle, input to out_valid. Throughput is 1 word/cycle when out_ready is held high.
//  Drain with no new transfer: out_valid <= 0; out_data and out_ch hold their values.
//  Stall: while out_valid & !out_ready, out_data, out_ch and out_valid are frozen, and all in_ready=0.
//  Simultaneous drain and load in the same cycle: the new word replaces the old one, no bubble.
//  rr_ptr <= i only on a transfer while mode=1. It is never changed in mode=0 or on idle cycles.
//  - Pointer wrap: after channel N_CH-1, the search wraps to channel 0.
//  Changing mode or sel mid-stream affects only the next grant. A held output word is never altered.
//  No input valid (or sel invalid in mode=0): no transfer, and in_ready=0.
//  Reset mid-operation: the pending output word is discarded, out_valid=0 immediately, rr_ptr returns to N_CH-1.
//  Sources must hold in_valid and data until ready. The block does not check this.
// STRUCTURE
//  Package data_sel_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1.
//  Sub-module rr_arbiter #(N_CH): inputs req, ptr; output one-hot gnt.
//  - Uses a double-width rotate and priority encode.
//  - The pointer register stays in data_sel_arb.
//  Top level contains the grant mux, in_ready gating, output register and rr_ptr register.
// TESTING  (N_CH=4, WIDTH=8)
//  1 Reset: rst_n=0 asserted mid-stall -> out_valid=0, out_data=0, out_ch=0 with no clock edge; first RR grant goes to ch0.
//  2 Fixed mode: mode=0, sel=2, in_valid=4'b1111, data ch2=8'hA5, out_ready=1
//    -> in_ready=4'b0100; next cycle out_data=A5, out_ch=2.
//    Then sel=3'd5 is not applicable; checking sel=2 with in_valid[2]=0 -> in_ready=0, out_valid drops.
//  3 Round robin: mode=1, in_valid=4'b1111 held, out_ready=1
//    -> out_ch sequence 0,1,2,3,0 on consecutive cycles (wrap-around).
//    With in_valid=4'b1010: sequence 1,3,1,3.
//  4 Backpressure: out_ready=0 for 3 cycles while out_valid=1
//    -> out_data and out_ch stable, in_ready=0.
//    On release: drain and load occur in the same cycle, so no bubble appears on out_valid.
//  5 Pointer hold: RR grants ch1, then 2 idle cycles, then switch to mode=0 with sel=3 for 2 transfers, then back to mode=1 with all valid
//    -> next grant is ch2.
//  6 Random: constrained-random valid, ready, mode and sel against a scoreboard model
//    -> no lost or duplicated words, out_ch correct, at most one in_ready bit high.

Source files
------------

// File: rtl/data_sel_pkg.sv
// Shared definitions for the registered N-channel data selector.
// Mode encodings used by the top level and the bench.
package data_sel_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after ptr.
// Stateless; the pointer register lives in the caller.
module rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt
);

  logic [SEL_W-1:0]  start;
  logic [2*N_CH-1:0] req2;
  logic [2*N_CH-1:0] gnt2;
  logic [N_CH-1:0]   rot;
  logic [N_CH-1:0]   prio;

  assign start = (ptr >= SEL_W'(N_CH-1)) ? '0 : ptr + 1'b1;
  assign req2  = {req, req};
  assign rot   = req2[start +: N_CH];
  // isolate the lowest set bit, then rotate back into place
  assign prio  = rot & (~rot + N_CH'(1));
  assign gnt2  = {prio, prio} << start;
  assign gnt   = gnt2[2*N_CH-1 -: N_CH];

endmodule

// File: rtl/data_sel_arb.sv
// Registered N-channel data selector, fixed or round-robin select,
// with valid/ready on every channel and one output register stage.
module data_sel_arb
  import data_sel_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  logic             load_en;
  logic             xfer;
  logic [N_CH-1:0]  rr_gnt;
  logic [N_CH-1:0]  fix_gnt;
  logic [N_CH-1:0]  grant;
  logic [WIDTH-1:0] nxt_data;
  logic [SEL_W-1:0] nxt_ch;
  logic [SEL_W-1:0] rr_ptr;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req (in_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  assign load_en = !out_valid | out_ready;

  // an out-of-range sel matches no channel
  always_comb begin
    fix_gnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(sel) == i) fix_gnt[i] = in_valid[i];
    end
  end

  always_comb begin
    grant = '0;
    unique case (mode)
      MODE_RR:    grant = rr_gnt;
      MODE_FIXED: grant = fix_gnt;
    endcase
  end

  assign in_ready = grant & {N_CH{load_en}};
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    nxt_data = '0;
    nxt_ch   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        nxt_data = in_data[i*WIDTH +: WIDTH];
        nxt_ch   = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(N_CH-1);
    end else begin
      if (load_en) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= nxt_data;
          out_ch   <= nxt_ch;
        end
      end
      if (xfer && mode == MODE_RR) rr_ptr <= nxt_ch;
    end
  end

endmodule

// File: tb/tb_data_sel_arb.sv
// Bench for data_sel_arb: directed sequences plus random traffic,
// checked against a reference grant model and a word scoreboard.
module tb_data_sel_arb;
  import data_sel_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] dat [4];
  logic [9:0] q [$];
  logic       m_valid;
  logic [1:0] m_ptr;

  data_sel_arb #(.N_CH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] mgrant(logic md, logic [1:0] s,
                                        logic [3:0] v, logic [1:0] p);
    logic [3:0] g;
    logic       found;
    int         c;
    g = '0;
    found = 1'b0;
    if (md == MODE_FIXED) begin
      g[s] = v[s];
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = (int'(p) + k) % 4;
        if (!found && v[c]) begin
          g[c] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 2'd3;
    q.delete();
  endtask

  // reset asserted between edges; outputs must clear with no clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic md, input logic [1:0] s,
                      input logic [3:0] v, input logic rdy,
                      input int exp_rdy);
    logic [3:0] g;
    logic       ld;
    logic [1:0] c;
    mode = md;
    sel = s;
    in_valid = v;
    out_ready = rdy;
    in_data = {dat[3], dat[2], dat[1], dat[0]};
    #1;
    ld = !m_valid || rdy;
    g = ld ? mgrant(md, s, v, m_ptr) : 4'b0;
    chk("in_ready", in_ready, g);
    if (exp_rdy >= 0) chk("dir_ready", in_ready, exp_rdy);
    chk("onehot", $countones(in_ready) <= 1, 1);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("sb_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0][7:0]);
        chk("out_ch", out_ch, q[0][9:8]);
        if (rdy) void'(q.pop_front());
      end
    end
    if (g != 0) begin
      c = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) c = 2'(i);
      q.push_back({c, dat[c]});
      if (md == MODE_RR) m_ptr = c;
    end
    if (ld) m_valid = (g != 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    mode = MODE_FIXED;
    sel = '0;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = 8'(i + 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // load a word, stall it, then reset mid-stall
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step(MODE_RR, 2'd0, 4'b0000, 1'b0, 4'b0000);
    do_reset();
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000);

    // fixed select
    dat[2] = 8'hA5;
    step(MODE_FIXED, 2'd2, 4'b1111, 1'b1, 4'b0100);
    step(MODE_FIXED, 2'd2, 4'b1011, 1'b1, 4'b0000);
    step(MODE_FIXED, 2'd2, 4'b0000, 1'b1, 4'b0000);

    // round robin with wrap, then sparse requests
    do_reset();
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0010);
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0100);
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b1000);
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010);
    step(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000);
    step(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010);
    step(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000);

    // backpressure for 3 cycles, then drain+load with no bubble
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001);
    for (int k = 0; k < 3; k++) step(MODE_RR, 2'd0, 4'b1111, 1'b0, 4'b0000);
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0010);
    step(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000);
    step(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000);

    // pointer holds across idle cycles and fixed-mode transfers
    do_reset();
    step(MODE_RR, 2'd0, 4'b0010, 1'b1, 4'b0010);
    step(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000);
    step(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000);
    step(MODE_FIXED, 2'd3, 4'b1111, 1'b1, 4'b1000);
    step(MODE_FIXED, 2'd3, 4'b1111, 1'b1, 4'b1000);
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0100);
    step(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      step(1'($urandom), 2'($urandom), 4'($urandom),
           ($urandom_range(0, 3) != 0), -1);
    end
    for (int n = 0; n < 3; n++) step(MODE_RR, 2'd0, 4'b0000, 1'b1, -1);
    chk("sb_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
